// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage ARMv8 pipeline. Each cycle
//   it picks one action (RUN, STALL, FLUSH or FREEZE) from the current inputs.
//   It drives the PC and pipeline-register enables for that action in the same
//   cycle. It also keeps saturating event counters and a sticky freeze-timeout
//   flag.
//
//   Ports
//     clock, reset              rising-edge clock, synchronous active-high reset
//     id_rn/id_rm               source registers of the instruction in ID
//     id_uses_rn/id_uses_rm     ID instruction actually reads that source
//     ex_memread, ex_rd         load in EX and its destination register
//     mem_branch_taken          taken branch resolved in MEM
//     dmem_busy                 data memory still working on the MEM access
//     pc_write .. pipe_en       per-cycle control enables (combinational)
//     state_q                   action taken last cycle (0 RUN,1 STALL,2 FLUSH,3 FREEZE)
//     stall_cnt/flush_cnt/
//     freeze_cnt                saturating event counters
//     freeze_timeout            sticky: FREEZE_LIMIT consecutive freeze cycles seen
//
//   Handshake: none. dmem_busy is a level that holds the whole pipeline while
//   it is high. Every other input is sampled combinationally in the same cycle.
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int FREEZE_LIMIT = 64,
  parameter int ZERO_REG     = 31
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             pc_src_branch,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_en,
  output logic [1:0]       state_q,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             freeze_timeout
);

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_STALL  = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_FREEZE = 2'd3
  } action_t;

  localparam int              CW      = $clog2(FREEZE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT_V = CW'(FREEZE_LIMIT);
  localparam logic [4:0]      ZR      = 5'(ZERO_REG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  action_t       action;
  action_t       state_r;
  logic          load_use;
  logic [CW-1:0] consec_q;
  logic [CW-1:0] consec_d;

  assign state_q = state_r;

  // Action select and per-cycle enables.
  always_comb begin
    load_use = ex_memread && (ex_rd != ZR) &&
               ((id_uses_rn && (id_rn == ex_rd)) ||
                (id_uses_rm && (id_rm == ex_rd)));

    // Priority: FREEZE over FLUSH over STALL. A flush squashes the ID
    // instruction, so a load-use hazard that comes with it does not matter.
    action = ACT_RUN;
    if (dmem_busy)             action = ACT_FREEZE;
    else if (mem_branch_taken) action = ACT_FLUSH;
    else if (load_use)         action = ACT_STALL;

    pc_write      = 1'b0;
    pc_src_branch = 1'b0;
    ifid_write    = 1'b0;
    idex_bubble   = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    pipe_en       = 1'b1;

    case (action)
      ACT_RUN: begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
      ACT_STALL: begin
        idex_bubble = 1'b1;
      end
      ACT_FLUSH: begin
        pc_write      = 1'b1;
        pc_src_branch = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        exmem_flush   = 1'b1;
      end
      ACT_FREEZE: begin
        pipe_en = 1'b0;
      end
      default: ;
    endcase

    // In reset, the pipeline is cleared to NOPs and the PC is held.
    if (reset) begin
      pc_write      = 1'b0;
      pc_src_branch = 1'b0;
      ifid_write    = 1'b0;
      idex_bubble   = 1'b0;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      pipe_en       = 1'b1;
    end
  end

  // Consecutive-freeze count. It stops at the limit so it cannot wrap back
  // below the limit during a very long freeze.
  always_comb begin
    consec_d = '0;
    if (action == ACT_FREEZE) begin
      consec_d = (consec_q == LIMIT_V) ? LIMIT_V : consec_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ACT_RUN;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
      freeze_cnt     <= '0;
      consec_q       <= '0;
      freeze_timeout <= 1'b0;
    end else begin
      state_r  <= action;
      consec_q <= consec_d;
      if (consec_d == LIMIT_V) freeze_timeout <= 1'b1;
      if (action == ACT_STALL && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (action == ACT_FLUSH && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 1'b1;
      if (action == ACT_FREEZE && freeze_cnt != CNT_MAX)
        freeze_cnt <= freeze_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. It runs with small counters (CNT_W=2) and a
// short freeze limit (4), so saturation and timeout are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W        = 2;
  localparam int FREEZE_LIMIT = 4;
  localparam int ZERO_REG     = 31;
  localparam int MAXC         = (1 << CNT_W) - 1;
  localparam int RW           = 2 + 3 * CNT_W + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset = 1'b1;
  logic [4:0]       id_rn = '0, id_rm = '0, ex_rd = '0;
  logic             id_uses_rn = 0, id_uses_rm = 0, ex_memread = 0;
  logic             mem_branch_taken = 0, dmem_busy = 0;
  logic             pc_write, pc_src_branch, ifid_write, idex_bubble;
  logic             ifid_flush, idex_flush, exmem_flush, pipe_en;
  logic [1:0]       state_q;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic             freeze_timeout;

  pipeline_hazard_ctrl #(
    .CNT_W(CNT_W), .FREEZE_LIMIT(FREEZE_LIMIT), .ZERO_REG(ZERO_REG)
  ) dut (
    .clock(clock), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_branch_taken(mem_branch_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .pc_src_branch(pc_src_branch), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pipe_en(pipe_en), .state_q(state_q),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt),
    .freeze_timeout(freeze_timeout)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Action codes: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE.
  function automatic int model_action();
    bit hazard;
    hazard = ex_memread && (int'(ex_rd) != ZERO_REG) &&
             ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
    if (dmem_busy)        return 3;
    if (mem_branch_taken) return 2;
    if (hazard)           return 1;
    return 0;
  endfunction

  // {pc_write, pc_src_branch, ifid_write, idex_bubble,
  //  ifid_flush, idex_flush, exmem_flush, pipe_en}
  function automatic logic [7:0] model_ctrl(input bit rst, input int act);
    if (rst) return 8'b0000_1111;
    case (act)
      0:       return 8'b1010_0001;
      1:       return 8'b0001_0001;
      2:       return 8'b1110_1111;
      default: return 8'b0000_0000;
    endcase
  endfunction

  int m_state = 0, m_stall = 0, m_flush = 0, m_freeze = 0, m_consec = 0;
  bit m_timeout = 0;
  logic [RW-1:0] exp_q[$];

  always @(posedge clock) begin
    int a;
    if (reset) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_freeze = 0; m_consec = 0; m_timeout = 0;
    end else begin
      a = model_action();
      m_state = a;
      if (a == 1) m_stall  = (m_stall  < MAXC) ? m_stall  + 1 : MAXC;
      if (a == 2) m_flush  = (m_flush  < MAXC) ? m_flush  + 1 : MAXC;
      if (a == 3) m_freeze = (m_freeze < MAXC) ? m_freeze + 1 : MAXC;
      m_consec = (a == 3) ? ((m_consec < FREEZE_LIMIT) ? m_consec + 1 : FREEZE_LIMIT) : 0;
      if (m_consec >= FREEZE_LIMIT) m_timeout = 1;
    end
    exp_q.push_back({2'(m_state), CNT_W'(m_stall), CNT_W'(m_flush),
                     CNT_W'(m_freeze), m_timeout});
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clock) begin
    logic [RW-1:0] e;
    check("ctrl", {pc_write, pc_src_branch, ifid_write, idex_bubble,
                   ifid_flush, idex_flush, exmem_flush, pipe_en},
          model_ctrl(reset, model_action()));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("regs", {state_q, stall_cnt, flush_cnt, freeze_cnt, freeze_timeout}, e);
    end
  end

  // ---------------- driver tasks ----------------
  // Applies one cycle of inputs shortly after the rising edge and returns at the
  // following falling edge. The outputs for those inputs are then settled.
  task automatic drive(input bit rst, input bit busy, input bit taken,
                       input bit mr, input logic [4:0] rd,
                       input bit urn, input logic [4:0] rn,
                       input bit urm, input logic [4:0] rm);
    @(posedge clock);
    #2;
    reset = rst; dmem_busy = busy; mem_branch_taken = taken;
    ex_memread = mr; ex_rd = rd;
    id_uses_rn = urn; id_rn = rn; id_uses_rm = urm; id_rm = rm;
    @(negedge clock);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    idle();
  endtask

  task automatic busy_cycles(input int n, input bit taken);
    for (int i = 0; i < n; i++) drive(0, 1, taken, 0, 5'd0, 0, 5'd0, 0, 5'd0);
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    drive(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    check("rst_pc_write", pc_write, 0);
    check("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
    check("rst_pipe_en", pipe_en, 1);
    idle();
    check("rst_state", state_q, 0);
    check("rst_cnts", {stall_cnt, flush_cnt, freeze_cnt, freeze_timeout}, 0);

    // Load-use on Rn.
    drive(0, 0, 0, 1, 5'd5, 1, 5'd5, 0, 5'd0);
    check("lu_ctrl", {pc_write, ifid_write, idex_bubble}, 3'b001);
    idle();
    check("lu_state", state_q, 1);
    check("lu_cnt", stall_cnt, 1);
    // Same pattern against XZR is not a hazard.
    drive(0, 0, 0, 1, 5'd31, 1, 5'd31, 0, 5'd0);
    check("xzr_run", {pc_write, ifid_write, idex_bubble}, 3'b110);
    idle();
    check("xzr_cnt", stall_cnt, 1);

    // Rm path, then the same without a load.
    drive(0, 0, 0, 1, 5'd9, 0, 5'd0, 1, 5'd9);
    check("rm_stall", idex_bubble, 1);
    drive(0, 0, 0, 0, 5'd9, 0, 5'd0, 1, 5'd9);
    check("rm_run", {pc_write, idex_bubble}, 2'b10);
    idle();
    check("rm_cnt", stall_cnt, 2);

    // Branch with a simultaneous load-use hazard: the flush wins.
    do_reset();
    drive(0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0);
    check("br_ctrl", {pc_write, pc_src_branch, idex_bubble, ifid_flush, idex_flush, exmem_flush},
          6'b110111);
    idle();
    check("br_cnts", {flush_cnt, stall_cnt}, {2'd1, 2'd0});
    check("br_state", state_q, 2);

    // Freeze holds a branch; it flushes on the first free cycle.
    do_reset();
    busy_cycles(3, 1);
    check("frz_ctrl", {pipe_en, ifid_flush, pc_write, pc_src_branch}, 4'b0000);
    drive(0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    check("frz_then_flush", {ifid_flush, pc_src_branch}, 2'b11);
    idle();
    check("frz_cnts", {freeze_cnt, flush_cnt, freeze_timeout}, {2'd3, 2'd1, 1'b0});

    // Timeout: two broken runs of 3 stay clear, a run of 4 sets the flag.
    do_reset();
    busy_cycles(3, 0);
    idle();
    busy_cycles(3, 0);
    idle();
    check("to_gap", freeze_timeout, 0);
    busy_cycles(4, 0);
    idle();
    check("to_set", freeze_timeout, 1);
    check("frz_sat", freeze_cnt, MAXC);
    idle();
    check("to_sticky", freeze_timeout, 1);

    // Stall counter saturation.
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 5'd7, 1, 5'd7, 0, 5'd0);
    idle();
    check("stall_sat", stall_cnt, 3);

    // Reset in the middle of a freeze.
    do_reset();
    busy_cycles(2, 0);
    drive(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    check("midrst_ctrl", {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_en}, 5'b00011);
    idle();
    check("midrst_regs", {state_q, stall_cnt, flush_cnt, freeze_cnt, freeze_timeout}, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
